fix_msg_fifo: RTL and testbench
===============================

Name: fix_msg_fifo

Overview:
- Byte-wide store-and-forward buffer between a fix_engine transmit port and the TOE/peer receive port.
- Accepts bytes on the engine's fifo_write/message interface.
- A write-side trailer detector finds the end of each FIX message ("<SOH>10=ddd<SOH>", SOH = 8'h01). Only complete messages are released downstream, with first/last byte markers.
- Also returns fifo_full to the engine.

Parameters:
- SIZE, 64, FIFO depth in bytes; power of two, at least 16.
- ADDR_W, 6, log2(SIZE).
- CNT_W, 7, width of the stored-byte and complete-message counters (ADDR_W+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fifo_write_i  in  1  engine write strobe
- message_i  in  8  engine byte
- fifo_full_o  out  1  buffer full; engine must not write
- rd_valid_o  out  1  byte available from a complete message
- rd_ready_i  in  1  downstream accepts byte
- rd_data_o  out  8  output byte
- rd_first_o  out  1  rd_data_o is the first byte of a message
- rd_last_o  out  1  rd_data_o is the terminating SOH of a message
- msg_count_o  out  CNT_W  complete messages buffered
- overflow_o  out  1  sticky; set on dropped write or deadlock flush; cleared by rst only

Behaviour:
- Reset values: all pointers and counters 0; fifo_full_o=0; rd_valid_o=0; rd_first_o=1; rd_last_o=0; msg_count_o=0; overflow_o=0; trailer FSM in IDLE. Memory contents are don't-care.
- Storage:
  - SIZE x 9-bit RAM, holding the byte plus a last flag.
  - Circular wr_ptr and rd_ptr, ADDR_W bits; both wrap from SIZE-1 to 0.
  - Byte count held in CNT_W bits.
  - fifo_full_o = (count == SIZE), registered value.
- Write: when fifo_write_i && !fifo_full_o, store {last, message_i} at wr_ptr, increment wr_ptr, increment count. The last flag comes from the trailer FSM in the same cycle.
- Write while full: the byte is dropped, overflow_o is set, and the FSM does not advance.
- Trailer FSM:
  - States: IDLE, SOH, ONE, ZERO, EQ, D1, D2, D3.
  - Advances only on accepted writes.
  - IDLE --SOH--> SOH. SOH --'1'--> ONE. ONE --'0'--> ZERO. ZERO --'='--> EQ.
  - EQ --digit ('0'..'9')--> D1 --digit--> D2 --digit--> D3.
  - D3 --SOH--> the byte is flagged last, msg_count increments, and the FSM goes to IDLE.
  - Any mismatch: go to SOH if the byte is SOH, else IDLE.
  - In state SOH, a further SOH stays in SOH.
- Read:
  - First-word-fall-through. rd_data_o and rd_last_o reflect the RAM entry at rd_ptr.
  - rd_valid_o = (msg_count_o > 0). Bytes of an incomplete message are never presented.
  - Transfer occurs when rd_valid_o && rd_ready_i. On transfer: rd_ptr increments and count decrements.
  - rd_first_o is a register: set after a transfer with rd_last_o=1, cleared after any other transfer.
  - On a transfer with rd_last_o=1, msg_count decrements.
- Simultaneous events:
  - A write and a read in the same cycle leave count unchanged. Writing is permitted in a full cycle only if a read also occurs? No: full is evaluated before the read, so the write is dropped.
  - Trailer completion and last-byte read in the same cycle leave msg_count unchanged.
- Latency: a terminating SOH written in cycle N gives rd_valid_o=1 in cycle N+1.
- Deadlock flush: when count == SIZE and msg_count_o == 0, the following cycle does all of:
  - pointers and count reset to 0;
  - FSM to IDLE;
  - rd_first_o set to 1;
  - overflow_o set.
- Reset mid-operation discards all contents, including partially read messages. Downstream sees rd_valid_o=0 the cycle after rst.
- rd_ready_i is ignored while rd_valid_o=0.

Test Plan:
- Write "8=FIX.4.2|9=5|35=0|10=161|" (| = 8'h01, 26 bytes), rd_ready_i=1 -> rd_valid_o stays 0 until the cycle after the final SOH. Then 26 consecutive bytes out: rd_first_o on '8', rd_last_o on the final SOH. msg_count_o goes 1 -> 0.
- Write "35=0|10=16|" then "10=1a3|" (malformed trailers) -> msg_count_o stays 0 and rd_valid_o stays 0. Then write "10=123|" -> message released; its rd_last_o lands only on the final SOH.
- Two back-to-back messages with rd_ready_i toggling 1/0 each cycle -> bytes emerge in order with no duplication. rd_first_o is asserted on the first byte of the second message. msg_count_o goes 2 -> 1 -> 0.
- Write 64 bytes with no trailer -> fifo_full_o=1. The next cycle flushes: count 0, overflow_o=1, fifo_full_o=0. A subsequent valid message passes normally.
- Fill with one 64-byte complete message and attempt a 65th write -> that byte is dropped and overflow_o=1. Draining yields exactly 64 bytes. Pointers wrap and a following message reads correctly.
- Assert rst after 10 bytes of a released message have been read -> the next cycle shows rd_valid_o=0, msg_count_o=0, rd_first_o=1, overflow_o=0.

Source files
------------

// File: rtl/fix_msg_fifo.sv
// fix_msg_fifo: byte-wide store-and-forward buffer between the FIX engine
// transmit port and the downstream receiver. A write-side trailer detector
// marks the terminating SOH of "<SOH>10=ddd<SOH>". Downstream sees only
// bytes that belong to fully written messages.
module fix_msg_fifo #(
  parameter int SIZE   = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_write_i,
  input  logic [7:0]       message_i,
  output logic             fifo_full_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_first_o,
  output logic             rd_last_o,
  output logic [CNT_W-1:0] msg_count_o,
  output logic             overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOH, S_ONE, S_ZERO, S_EQ, S_D1, S_D2, S_D3
  } state_t;

  logic [8:0]        r_mem [SIZE];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, r_msg_cnt;
  logic              r_full, r_first, r_ovf;
  state_t            r_state;

  logic              w_wr, w_rd, w_rd_last, w_done, w_done_acc, w_flush;
  logic              w_is_soh, w_digit;
  logic [8:0]        w_head;
  logic [CNT_W-1:0]  w_count_nxt;
  state_t            w_state_nxt;

  assign w_is_soh = (message_i == 8'h01);
  assign w_digit  = (message_i >= 8'h30) && (message_i <= 8'h39);

  // Writes are judged against the registered full flag, so a write in a
  // full cycle is dropped even if a read frees a slot in the same cycle.
  assign w_wr       = fifo_write_i && !r_full;
  assign w_done_acc = w_wr && w_done;

  assign w_head     = r_mem[r_rd_ptr];
  assign rd_valid_o = (r_msg_cnt != '0);
  assign w_rd       = rd_valid_o && rd_ready_i;
  assign w_rd_last  = w_rd && w_head[8];

  // Buffer packed with an unterminated message can never drain: flush it.
  assign w_flush     = (r_count == CNT_W'(SIZE)) && (r_msg_cnt == '0);
  assign w_count_nxt = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

  assign rd_data_o   = w_head[7:0];
  assign rd_last_o   = rd_valid_o && w_head[8];
  assign rd_first_o  = r_first;
  assign fifo_full_o = r_full;
  assign msg_count_o = r_msg_cnt;
  assign overflow_o  = r_ovf;

  // Trailer matcher: next state and end-of-message detection for the current byte.
  always_comb begin
    w_state_nxt = w_is_soh ? S_SOH : S_IDLE;
    w_done      = 1'b0;
    case (r_state)
      S_SOH:  if (message_i == 8'h31) w_state_nxt = S_ONE;
      S_ONE:  if (message_i == 8'h30) w_state_nxt = S_ZERO;
      S_ZERO: if (message_i == 8'h3D) w_state_nxt = S_EQ;
      S_EQ:   if (w_digit) w_state_nxt = S_D1;
      S_D1:   if (w_digit) w_state_nxt = S_D2;
      S_D2:   if (w_digit) w_state_nxt = S_D3;
      S_D3:   if (w_is_soh) begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
              end
      default: ;
    endcase
  end

  // Storage write: byte plus end-of-message flag.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_wr_ptr] <= {w_done, message_i};
  end

  // Pointers, counters, trailer state and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_msg_cnt <= '0;
      r_full    <= 1'b0;
      r_first   <= 1'b1;
      r_ovf     <= 1'b0;
      r_state   <= S_IDLE;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_first   <= 1'b1;
      r_ovf     <= 1'b1;
      r_state   <= S_IDLE;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_state  <= w_state_nxt;
      end
      if (fifo_write_i && r_full) r_ovf <= 1'b1;
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_first  <= w_rd_last;
      end
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CNT_W'(SIZE));
      r_msg_cnt <= r_msg_cnt + CNT_W'(w_done_acc) - CNT_W'(w_rd_last);
    end
  end

endmodule

// File: tb/tb_fix_msg_fifo.sv
// tb_fix_msg_fifo: queue-based reference model of the message buffer,
// directed scenarios plus randomized traffic, checked every cycle.
module tb_fix_msg_fifo;
  localparam int SIZE = 64;
  localparam int CNT_W = 7;
  localparam string MSG1 = "8=FIX.4.2|9=5|35=0|10=161|";

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_write_i = 1'b0;
  logic [7:0]       message_i = 8'h00;
  logic             rd_ready_i = 1'b0;
  logic             fifo_full_o, rd_valid_o, rd_first_o, rd_last_o, overflow_o;
  logic [7:0]       rd_data_o;
  logic [CNT_W-1:0] msg_count_o;

  fix_msg_fifo #(.SIZE(SIZE), .ADDR_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_write_i(fifo_write_i), .message_i(message_i),
    .fifo_full_o(fifo_full_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .rd_first_o(rd_first_o), .rd_last_o(rd_last_o),
    .msg_count_o(msg_count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [8:0] q[$];
  logic [7:0] hist[$];
  int  m_msgs;
  bit  m_first, m_ovf, m_known;
  int  checks, errors, xfers;
  bit  tog;
  logic [7:0] gen[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_dig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // A message ends when the last eight accepted bytes since the previous
  // boundary spell <SOH>10=ddd<SOH>.
  function automatic bit trailer_hit();
    int n = hist.size();
    if (n < 8) return 1'b0;
    return hist[n-8] == 8'h01 && hist[n-7] == 8'h31 && hist[n-6] == 8'h30 &&
           hist[n-5] == 8'h3D && is_dig(hist[n-4]) && is_dig(hist[n-3]) &&
           is_dig(hist[n-2]) && hist[n-1] == 8'h01;
  endfunction

  task automatic model_step(input bit w, input logic [7:0] b, input bit rdy, input bit r);
    logic [8:0] e;
    bit full, done;
    if (r) begin
      q.delete(); hist.delete();
      m_msgs = 0; m_first = 1'b1; m_ovf = 1'b0; m_known = 1'b1;
      return;
    end
    full = (q.size() == SIZE);
    if (full && m_msgs == 0) begin
      q.delete(); hist.delete();
      m_first = 1'b1; m_ovf = 1'b1;
      return;
    end
    if (w && full) m_ovf = 1'b1;
    if (m_msgs > 0 && rdy) begin
      e = q.pop_front();
      if (e[8]) begin m_msgs--; m_first = 1'b1; end
      else m_first = 1'b0;
    end
    if (w && !full) begin
      hist.push_back(b);
      done = trailer_hit();
      if (done) begin m_msgs++; hist.delete(); end
      q.push_back({done, b});
    end
  endtask

  // One clock: compare outputs against the model, drive inputs, advance.
  task automatic cyc(input bit w, input logic [7:0] b, input bit rdy, input bit r);
    if (m_known) begin
      chk("rd_valid", rd_valid_o, m_msgs > 0);
      chk("msg_count", msg_count_o, m_msgs);
      chk("fifo_full", fifo_full_o, q.size() == SIZE);
      chk("overflow", overflow_o, m_ovf);
      chk("rd_first", rd_first_o, m_first);
      if (m_msgs > 0) begin
        chk("rd_data", rd_data_o, q[0][7:0]);
        chk("rd_last", rd_last_o, q[0][8]);
      end
    end
    if (rd_valid_o && rdy && !r) xfers++;
    fifo_write_i = w; message_i = b; rd_ready_i = rdy; rst = r;
    model_step(w, b, rdy, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) begin tog = ~tog; return tog; end
    return mode[0];
  endfunction

  task automatic send_str(input string s, input int mode);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "|") c = 8'h01;
      cyc(1'b1, c, pick_rdy(mode), 1'b0);
    end
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, pick_rdy(mode), 1'b0);
  endtask

  task automatic build_msg();
    string alpha = "AB=5|10";
    logic [7:0] c;
    int n = $urandom_range(0, 20);
    int bad;
    for (int i = 0; i < n; i++) begin
      c = alpha[$urandom_range(0, 6)];
      gen.push_back(c == "|" ? 8'h01 : c);
    end
    gen.push_back(8'h01); gen.push_back(8'h31); gen.push_back(8'h30); gen.push_back(8'h3D);
    bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
    for (int i = 0; i < 3; i++)
      gen.push_back(i == bad ? 8'h78 : 8'(8'h30 + $urandom_range(0, 9)));
    gen.push_back(8'h01);
  endtask

  initial begin
    string big;
    bit w, rdy, r;
    logic [7:0] b;
    checks = 0; errors = 0; xfers = 0; tog = 1'b0; m_known = 1'b0;

    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_valid", rd_valid_o, 0);
    chk("reset_first", rd_first_o, 1);
    chk("reset_last", rd_last_o, 0);
    chk("reset_full", fifo_full_o, 0);

    // complete message, reader always ready
    send_str(MSG1, 1);
    chk("m1_valid", rd_valid_o, 1);
    chk("m1_count", msg_count_o, 1);
    chk("m1_data", rd_data_o, 8'h38);
    chk("m1_first", rd_first_o, 1);
    xfers = 0;
    idle(30, 1);
    chk("m1_xfers", xfers, 26);
    chk("m1_count_end", msg_count_o, 0);

    // malformed trailers then a good one
    send_str("35=0|10=16|", 1);
    send_str("10=1a3|", 1);
    chk("bad_count", msg_count_o, 0);
    chk("bad_valid", rd_valid_o, 0);
    send_str("10=123|", 1);
    chk("good_count", msg_count_o, 1);
    xfers = 0;
    idle(30, 1);
    chk("good_xfers", xfers, 25);

    // two messages, ready toggling
    xfers = 0;
    send_str(MSG1, 2);
    send_str("A=1|10=007|", 2);
    idle(80, 2);
    chk("two_xfers", xfers, 37);

    // deadlock flush
    for (int i = 0; i < SIZE; i++) cyc(1'b1, 8'h41, 1'b1, 1'b0);
    chk("dl_full", fifo_full_o, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("dl_full_clr", fifo_full_o, 0);
    chk("dl_ovf", overflow_o, 1);
    send_str(MSG1, 1);
    idle(30, 1);

    // full complete message, dropped 65th byte, wrap
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_ovf", overflow_o, 0);
    big = "";
    for (int i = 0; i < 56; i++) big = {big, "B"};
    big = {big, "|10=000|"};
    send_str(big, 0);
    chk("big_full", fifo_full_o, 1);
    chk("big_count", msg_count_o, 1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("big_ovf", overflow_o, 1);
    xfers = 0;
    idle(70, 1);
    chk("big_xfers", xfers, 64);
    send_str(MSG1, 1);
    idle(30, 1);

    // reset mid-read
    send_str(MSG1, 0);
    idle(10, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_valid", rd_valid_o, 0);
    chk("mid_count", msg_count_o, 0);
    chk("mid_first", rd_first_o, 1);
    chk("mid_ovf", overflow_o, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (gen.size() == 0) build_msg();
      w = ($urandom_range(0, 9) < 7);
      b = 8'h00;
      if (w) b = gen.pop_front();
      rdy = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 799) == 0);
      cyc(w, b, rdy, r);
    end
    idle(5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
